// File: rtl/mac_arbiter_if.sv
// rtl/mac_arbiter_if.sv - requester and response bundle for mac_arbiter
interface mac_arbiter_if #(
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = 16,
  parameter int NREQ      = 4
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*WIDTH-1:0] req_c;
  logic                  rsp_valid;
  logic [1:0]            rsp_id;
  logic [OUT_WIDTH-1:0]  rsp_data;

  // Requester side: offers operands, sees grants and responses
  modport master (
    output req_valid, req_a, req_b, req_c,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_a, req_b, req_c,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/mac_arbiter.sv
// rtl/mac_arbiter.sv - round-robin arbiter sharing one pipelined MAC among 4 requesters
module mac_arbiter #(
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = 16,
  parameter int NREQ      = 4,
  parameter int LATENCY   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mac_arbiter_if.slave         bus,
  output logic [WIDTH-1:0]     mac_a,
  output logic [WIDTH-1:0]     mac_b,
  output logic [WIDTH-1:0]     mac_c,
  input  logic [OUT_WIDTH-1:0] mac_result,
  output logic                 busy,
  output logic [15:0]          issue_cnt
);

  // Index of the requester with highest priority this cycle
  logic [1:0]                   ptr;
  logic [1:0]                   cand;
  logic [1:0]                   gnt_idx;
  logic                         gnt_any;
  // Per-stage valid/id of operations travelling alongside the MAC pipeline
  logic [LATENCY-1:0]           vld_sr;
  logic [LATENCY-1:0][1:0]      id_sr;

  // Search from ptr upward (wrapping) for the first valid requester; no grant in reset
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = ptr;
    cand    = ptr;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr + 2'(k);
      if (!gnt_any && bus.req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (!rst_n) begin
      gnt_any = 1'b0;
    end
  end

  assign bus.req_ready = gnt_any ? (NREQ'(1) << gnt_idx) : '0;

  // Steer the granted requester's operands to the MAC, zero when idle
  always_comb begin
    mac_a = '0;
    mac_b = '0;
    mac_c = '0;
    if (gnt_any) begin
      mac_a = bus.req_a[int'(gnt_idx)*WIDTH +: WIDTH];
      mac_b = bus.req_b[int'(gnt_idx)*WIDTH +: WIDTH];
      mac_c = bus.req_c[int'(gnt_idx)*WIDTH +: WIDTH];
    end
  end

  // Pointer, issue counter and the never-stalling tracking shift register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= '0;
      issue_cnt <= '0;
      vld_sr    <= '0;
      id_sr     <= '0;
    end else begin
      if (gnt_any) begin
        ptr       <= gnt_idx + 2'd1;
        issue_cnt <= issue_cnt + 16'd1;
      end
      vld_sr[0] <= gnt_any;
      id_sr[0]  <= gnt_any ? gnt_idx : 2'd0;
      for (int i = 1; i < LATENCY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        id_sr[i]  <= id_sr[i-1];
      end
    end
  end

  // The last stage lines up with mac_result for the operation it tracks
  assign bus.rsp_valid = rst_n & vld_sr[LATENCY-1];
  assign bus.rsp_id    = bus.rsp_valid ? id_sr[LATENCY-1] : 2'd0;
  assign bus.rsp_data  = bus.rsp_valid ? mac_result : '0;
  assign busy          = |vld_sr;

endmodule

// File: doc/mac_arbiter.md
MAC_ARBITER -- requirements
Module: mac_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, operand width of A, B and C.
REQ-002 Parameter OUT_WIDTH, default 16, result width; SHALL satisfy OUT_WIDTH >= 2*WIDTH.
REQ-003 Parameter NREQ, default 4, number of requesters; SHALL be fixed at 4.
REQ-004 Parameter LATENCY, default 3, MAC pipeline depth in cycles from operand sample to result.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 req_valid  in  NREQ  per-requester operand-valid.
REQ-008 req_ready  out  NREQ  per-requester grant/accept, one-hot or zero.
REQ-009 req_a, req_b, req_c  in  NREQ*WIDTH each  operands; requester i occupies slice [i*WIDTH +: WIDTH].
REQ-010 mac_a, mac_b, mac_c  out  WIDTH each  operands driven to the shared MAC.
REQ-011 mac_result  in  OUT_WIDTH  MAC output (A*B + C), valid LATENCY cycles after operand sample.
REQ-012 rsp_valid  out  1  response-valid pulse.
REQ-013 rsp_id  out  2  requester index owning the response.
REQ-014 rsp_data  out  OUT_WIDTH  response result.
REQ-015 busy  out  1  high while any operation is in flight.
REQ-016 issue_cnt  out  16  total accepted operations, free-running.

Function
REQ-017 Arbitration SHALL be round-robin: priority starts at the index after the last granted requester, wrapping 3 -> 0.
REQ-018 At most one req_ready bit SHALL be high per cycle, and only for a requester with req_valid high.
REQ-019 req_ready SHALL be combinational from req_valid and the registered priority pointer.
REQ-020 A transfer occurs in a cycle where req_valid[i] and req_ready[i] are both high.
REQ-021 Requesters SHALL hold req_valid and operands stable until their transfer; the block does not latch unaccepted operands.
REQ-022 mac_a/b/c SHALL carry the granted requester's operands combinationally in the transfer cycle, and zero when no grant.
REQ-023 The priority pointer SHALL update only on a transfer, to granted index + 1 mod 4.
REQ-024 A transfer in cycle n SHALL produce rsp_valid=1 in cycle n+LATENCY, with rsp_id = granted index and rsp_data = mac_result.
REQ-025 Valid/id SHALL be tracked in a LATENCY-deep shift register advancing every cycle; the pipeline never stalls, and responses have no backpressure.
REQ-026 rsp_valid SHALL be 0 in every cycle without a matching transfer LATENCY cycles earlier; rsp_data SHALL be 0 when rsp_valid is 0.
REQ-027 Back-to-back transfers SHALL yield back-to-back responses, one per cycle, in issue order.
REQ-028 busy SHALL be the OR of the tracking shift register valid bits.
REQ-029 issue_cnt SHALL increment by 1 per transfer and wrap from 0xFFFF to 0x0000.
REQ-030 A requester deasserting req_valid while another is waiting SHALL not disturb the pointer.

Reset
REQ-031 While rst_n=0 at a rising edge: pointer=0, tracking valid bits=0, ids=0, and issue_cnt=0.
REQ-032 While rst_n=0 at a rising edge: rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, and req_ready=0.
REQ-033 Operations in flight at reset SHALL be discarded: no rsp_valid for them after rst_n returns high, regardless of mac_result contents.
REQ-034 The first cycle with rst_n=1 SHALL arbitrate normally, with requester 0 at highest priority.

Verification
REQ-035 Single op: req_valid=0001, A=3, B=4, C=5 in cycle n -> req_ready=0001 in cycle n; rsp_valid=1, rsp_id=0, rsp_data=17 in cycle n+3; issue_cnt=1.
REQ-036 All request: req_valid=1111 held -> grants 0,1,2,3,0 in consecutive cycles; responses follow on consecutive cycles in the same order, ids and data matching.
REQ-037 Fairness: after a grant to 2, with req_valid=1101 -> next grant is 3, then 0, then 2.
REQ-038 Max values: A=255, B=255, C=255 -> rsp_data=65280 (0xFF00), no truncation.
REQ-039 Reset mid-flight: 2 ops issued, rst_n=0 for 1 cycle one cycle later -> no rsp_valid afterwards, busy=0, issue_cnt=0, and next grant goes to requester 0.
REQ-040 Counter wrap: 65536 transfers -> issue_cnt returns to 0x0000 with no effect on responses.
